// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter; data reg queues bytes into a FIFO, status reg reports {ovf,busy,empty,full}, 8N1 serial out on tx (8E1 when UART_PARITY_EN is defined)
// Ports: clk/reset (sync active-high); wr/reade/addr/wr_data snoop the MEM-stage bus;
//        rd_data (combinational status word), hit (address claimed), tx (registered serial line, idle high)
module mmio_uart_tx #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter logic [DM_ADDRESS-1:0] TX_ADDR = 9'h1F0,
  parameter logic [DM_ADDRESS-1:0] STAT_ADDR = 9'h1F4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  reade,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  hit,
  output logic                  tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic push_req, stat_rd, full, empty, busy, bit_end, push, pop;
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data[DATA_W-1:8];
  assign push_req = wr && addr == TX_ADDR;
  assign stat_rd = reade && addr == STAT_ADDR;
  assign full = count_q == (AW+1)'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign busy = state_q != IDLE;
  assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign push = push_req && !full;
  // Popping at the last stop-bit cycle keeps queued frames gap-free.
  assign pop = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign hit = (wr || reade) && (addr == TX_ADDR || addr == STAT_ADDR);
  assign rd_data = stat_rd ? {{(DATA_W-4){1'b0}}, ovf_q, busy, empty, full} : '0;
  assign tx = tx_q;
  always_comb begin
    state_d = state_q;
    cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    shift_d = shift_q;
    tx_d = tx_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d = 1'b1;
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d = 3'd0;
        tx_d = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
          state_d = PARITY;
          tx_d = ^shift_q;
`else
          state_d = STOP;
          tx_d = 1'b1;
`endif
        end else begin
          idx_d = idx_q + 3'd1;
          tx_d = shift_q[idx_q + 3'd1];
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        state_d = IDLE;
        tx_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      cnt_d = '0;
      shift_d = mem_q[head_q];
      tx_d = 1'b0;
    end
    head_d = pop ? head_q + AW'(1) : head_q;
    tail_d = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = (push_req && full) || (ovf_q && !stat_rd);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= wr_data[7:0];
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized scoreboard bench for mmio_uart_tx with a frame-timing reference model
module tb_mmio_uart_tx;
  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * C;
  localparam logic [8:0] TXA = 9'h1F0;
  localparam logic [8:0] STA = 9'h1F4;
  logic clk = 0, reset = 1, wr = 0, reade = 0;
  logic [8:0] addr = 0;
  logic [31:0] wr_data = 0, rd_data;
  logic hit, tx;
  mmio_uart_tx #(.FIFO_DEPTH(D), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .wr(wr), .reade(reade), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .hit(hit), .tx(tx)
  );
  always #5 clk = ~clk;
  int cyc = 0, last_rst = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) last_rst <= cyc + 1;
  end
  int tests = 0, fails = 0;
  typedef struct packed {logic h; logic [31:0] rd;} acc_t;
  typedef struct packed {logic [7:0] d; int pop;} frm_t;
  acc_t acc_q[$];
  frm_t frm_q[$];
  int push_e[$], pop_e[$];
  bit ovf_m = 0;
  // Occupancy at edge e: bytes written before e that have not yet been popped before e.
  function automatic int cnt_at(int e);
    int n = 0;
    foreach (push_e[i]) if (push_e[i] < e && pop_e[i] >= e) n++;
    return n;
  endfunction
  function automatic bit busy_at(int e);
    foreach (pop_e[i]) if (pop_e[i] < e && e <= pop_e[i] + FL) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [31:0] stat_at(int e);
    int n = cnt_at(e);
    return {28'b0, ovf_m, busy_at(e), n == 0, n == D};
  endfunction
  task automatic drive(bit r, bit w, bit rd, logic [8:0] a, logic [7:0] d);
    int e, p;
    acc_t x;
    bit drop;
    @(negedge clk);
    reset = r; wr = w; reade = rd; addr = a;
    wr_data = $urandom();
    wr_data[7:0] = d;
    e = cyc + 1;
    if (w || rd) begin
      x.h = (a == TXA || a == STA);
      x.rd = (rd && a == STA) ? stat_at(e) : 32'h0;
      acc_q.push_back(x);
    end
    if (r) begin
      push_e.delete(); pop_e.delete(); frm_q.delete(); ovf_m = 0;
    end else begin
      drop = 0;
      if (w && a == TXA) begin
        if (cnt_at(e) < D) begin
          p = e + 1;
          if (pop_e.size() > 0 && pop_e[$] + FL > p) p = pop_e[$] + FL;
          push_e.push_back(e); pop_e.push_back(p); frm_q.push_back('{d, p});
        end else drop = 1;
      end
      if (rd && a == STA) ovf_m = 0;
      if (drop) ovf_m = 1;
    end
  endtask
  task automatic idle(int n); repeat (n) drive(0, 0, 0, 9'h0, 8'h0); endtask
  task automatic rd_stat; drive(0, 0, 1, STA, 8'h0); endtask
  task automatic wr_tx(logic [7:0] d); drive(0, 1, 0, TXA, d); endtask
  acc_t ax;
  always @(negedge clk) begin
    #2;
    tests++;
    if (wr || reade) begin
      if (acc_q.size() == 0) begin
        fails++;
        $display("FAIL access: no expectation, hit=%0b rd_data=%h", hit, rd_data);
      end else begin
        ax = acc_q.pop_front();
        if (hit !== ax.h || rd_data !== ax.rd) begin
          fails++;
          $display("FAIL access @%0d addr=%h: hit=%0b rd_data=%h, expected hit=%0b rd_data=%h", cyc, addr, hit, rd_data, ax.h, ax.rd);
        end
      end
    end else if (hit !== 1'b0 || rd_data !== 32'h0) begin
      fails++;
      $display("FAIL idle_bus @%0d: hit=%0b rd_data=%h, expected 0/0", cyc, hit, rd_data);
    end
  end
  int p0, fk;
  bit in_fr = 0, bad;
  logic eb;
  logic [7:0] cur, obs;
  frm_t fx;
  always @(negedge clk) begin
    if (last_rst == cyc) in_fr = 0;
    else if (in_fr) begin
      fk = (cyc - p0) / C;
      eb = fk == 0 ? 1'b0 : fk <= 8 ? cur[fk-1] : (FB == 11 && fk == 9) ? ^cur : 1'b1;
      if (tx !== eb) bad = 1;
      if (fk >= 1 && fk <= 8 && (cyc - p0) % C == C / 2) obs[fk-1] = tx;
      if (cyc - p0 == FL - 1) begin
        tests++;
        in_fr = 0;
        if (bad) begin
          fails++;
          $display("FAIL frame @%0d: line carried %h, expected %h with correct framing", p0, obs, cur);
        end
      end
    end else if (tx === 1'b0) begin
      tests++;
      in_fr = 1; p0 = cyc; bad = 0; obs = 0;
      if (frm_q.size() == 0) begin
        fails++; cur = 8'h0;
        $display("FAIL start @%0d: unexpected frame, expected line idle", cyc);
      end else begin
        fx = frm_q.pop_front();
        cur = fx.d;
        if (fx.pop != cyc) begin
          fails++;
          $display("FAIL start_time: start bit after edge %0d, expected %0d", cyc, fx.pop);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int k, r;
    repeat (2) drive(1, 1, 0, TXA, 8'h55);
    rd_stat;
    idle(3);
    wr_tx(8'hA5);
    repeat (10) begin idle(3); rd_stat; end
    idle(5); rd_stat;
    for (int i = 0; i < 6; i++) wr_tx(8'($urandom()));
    rd_stat; rd_stat;
    idle(FL * 5 + 10);
    wr_tx(8'h00); wr_tx(8'hFF);
    idle(2 * FL + 5);
    drive(0, 1, 0, 9'h1EC, 8'h12);
    drive(0, 0, 1, TXA, 8'h0);
    drive(0, 1, 0, STA, 8'h0);
    rd_stat; idle(2);
    wr_tx(8'h3C); wr_tx(8'h81);
    idle(4 * C);
    drive(1, 0, 0, 9'h0, 8'h0);
    rd_stat;
    idle(FL + 10);
    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r <= 4) wr_tx(8'($urandom()));
      else if (r <= 6) rd_stat;
      else if (r == 7) drive(0, 1'($urandom()), 1'($urandom()), 9'($urandom_range(0, 511)), 8'($urandom()));
      else if (r == 8) idle(1);
      else drive(0, 1, 1, $urandom_range(0, 1) ? TXA : STA, 8'($urandom()));
    end
    k = 0;
    while ((frm_q.size() != 0 || in_fr) && k < 3000) begin idle(1); k++; end
    if (k >= 3000) begin
      fails++;
      $display("FAIL drain: %0d frames still pending, expected 0", frm_q.size());
    end
    rd_stat;
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
